sprite_fetch: RTL and testbench

- Reader side of the animation interface. Consumes the per-frame sprite-sheet offsets and flip flag produced by the animation block, plus the sprite screen position.
- For each active-video pixel from the VGA timing block, it computes the sprite-sheet ROM address and returns the palette index two cycles later.
- Also returns a hit flag (pixel is inside the sprite box and opaque) for the top-level pixel mux.
- Sits between the animation/player logic and the sheet ROM / colour mux in top.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_addr_gen.sv | 58 +++++
 rtl/sprite_fetch.sv | 89 ++++++++
 tb/tb_sprite_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite-sheet geometry and types for the sprite reader path.
// Holds cell/sheet sizes, derived address widths and the sheet coordinate type.
package sprite_pkg;

    localparam int SPRITE_W        = 32;
    localparam int SPRITE_H        = 32;
    localparam int SHEET_W         = 256;
    localparam int SHEET_H         = 128;
    localparam int TRANSPARENT_IDX = 0;

    localparam int SHEET_X_W  = $clog2(SHEET_W);
    localparam int SHEET_Y_W  = $clog2(SHEET_H);
    localparam int ROM_ADDR_W = SHEET_X_W + SHEET_Y_W;

    // Cell origin inside the sheet, as produced by the animation block.
    typedef struct packed {
        logic [SHEET_X_W-1:0] x;
        logic [SHEET_Y_W-1:0] y;
    } sheet_coord_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational stage 0: sprite box test, flip, optional 2x scale, sheet address.
// Ports: col/row/active pixel in, sx/sy box origin, offset + flip_h cell select,
// inbox and addr out. Macro SPRITE_SCALE2X_EN doubles the box size.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0]    col,
    input  logic [COORD_W-1:0]    row,
    input  logic                  active,
    input  logic [COORD_W-1:0]    sx,
    input  logic [COORD_W-1:0]    sy,
    input  sheet_coord_t          offset,
    input  logic                  flip_h,
    output logic                  inbox,
    output logic [ROM_ADDR_W-1:0] addr
);

`ifdef SPRITE_SCALE2X_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif

    localparam logic [COORD_W-1:0]   BOX_W = COORD_W'(SPRITE_W << SH);
    localparam logic [COORD_W-1:0]   BOX_H = COORD_W'(SPRITE_H << SH);
    localparam logic [SHEET_X_W-1:0] U_MAX = SHEET_X_W'(SPRITE_W - 1);

    logic [COORD_W-1:0]   du;
    logic [COORD_W-1:0]   dv;
    logic [COORD_W-1:0]   du_s;
    logic [COORD_W-1:0]   dv_s;
    logic [SHEET_X_W-1:0] u_raw;
    logic [SHEET_X_W-1:0] u;
    logic [SHEET_Y_W-1:0] v;
    logic [SHEET_X_W-1:0] sheet_x;
    logic [SHEET_Y_W-1:0] sheet_y;

    always_comb begin
        // Unsigned wrap: a box hanging off the left/top edge yields a huge
        // du/dv for the off-screen part, so it is clipped rather than wrapped.
        du      = col - sx;
        dv      = row - sy;
        du_s    = du >> SH;
        dv_s    = dv >> SH;
        inbox   = active & (du < BOX_W) & (dv < BOX_H);
        // Only the low bits matter once inbox holds (u < SPRITE_W).
        u_raw   = du_s[SHEET_X_W-1:0];
        u       = flip_h ? (U_MAX - u_raw) : u_raw;
        v       = dv_s[SHEET_Y_W-1:0];
        // Sheet dimensions are powers of two: natural overflow is the modulo.
        sheet_x = offset.x + u;
        sheet_y = offset.y + v;
        addr    = {sheet_y, sheet_x};
    end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite pixel fetch: frame-latched shadows, sheet ROM address, palette index.
// Ports: clk/rst, frame_tick, col/row/active_in, sprite_x/y, x/y_offset, flip_h,
// rom_addr/rom_data to the sheet ROM, pixel_idx/hit/valid two cycles later.
// Macro SPRITE_SCALE2X_EN (in sprite_addr_gen) selects a 2x scaled box.
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic [COORD_W-1:0]    col,
    input  logic [COORD_W-1:0]    row,
    input  logic                  active_in,
    input  logic [COORD_W-1:0]    sprite_x,
    input  logic [COORD_W-1:0]    sprite_y,
    input  logic [SHEET_X_W-1:0]  x_offset,
    input  logic [SHEET_Y_W-1:0]  y_offset,
    input  logic                  flip_h,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [COLOR_W-1:0]    rom_data,
    output logic [COLOR_W-1:0]    pixel_idx,
    output logic                  pixel_hit,
    output logic                  pixel_valid
);

    localparam logic [COLOR_W-1:0] TRANSP = COLOR_W'(TRANSPARENT_IDX);

    logic [COORD_W-1:0]    sx_q;
    logic [COORD_W-1:0]    sy_q;
    sheet_coord_t          off_q;
    logic                  flip_q;

    logic                  inbox;
    logic [ROM_ADDR_W-1:0] addr;
    logic                  inbox_d1;
    logic                  active_d1;

    // Shadows change only at frame start so a frame never tears; the pixel
    // sharing the frame_tick cycle still sees the previous values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q   <= '0;
            sy_q   <= '0;
            off_q  <= '0;
            flip_q <= 1'b0;
        end else if (frame_tick) begin
            sx_q   <= sprite_x;
            sy_q   <= sprite_y;
            off_q  <= '{x: x_offset, y: y_offset};
            flip_q <= flip_h;
        end
    end

    sprite_addr_gen #(
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .col    (col),
        .row    (row),
        .active (active_in),
        .sx     (sx_q),
        .sy     (sy_q),
        .offset (off_q),
        .flip_h (flip_q),
        .inbox  (inbox),
        .addr   (addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr    <= '0;
            inbox_d1    <= 1'b0;
            active_d1   <= 1'b0;
            pixel_idx   <= '0;
            pixel_hit   <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            rom_addr    <= inbox ? addr : '0;
            inbox_d1    <= inbox;
            active_d1   <= active_in;
            pixel_idx   <= inbox_d1 ? rom_data : TRANSP;
            pixel_hit   <= inbox_d1 & (rom_data != TRANSP);
            pixel_valid <= active_d1;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed table plus randomized pixels
// checked against an arithmetic reference model with a behavioural sheet ROM.
module tb_sprite_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [9:0]  col = '0;
    logic [9:0]  row = '0;
    logic        active_in = 1'b0;
    logic [9:0]  sprite_x = '0;
    logic [9:0]  sprite_y = '0;
    logic [7:0]  x_offset = '0;
    logic [6:0]  y_offset = '0;
    logic        flip_h = 1'b0;
    logic [14:0] rom_addr;
    logic [5:0]  rom_data;
    logic [5:0]  pixel_idx;
    logic        pixel_hit;
    logic        pixel_valid;

    logic [5:0]  rom [0:32767];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    sprite_fetch #(.COORD_W(10), .COLOR_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .col         (col),
        .row         (row),
        .active_in   (active_in),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .x_offset    (x_offset),
        .y_offset    (y_offset),
        .flip_h      (flip_h),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_idx   (pixel_idx),
        .pixel_hit   (pixel_hit),
        .pixel_valid (pixel_valid)
    );

`ifdef SPRITE_SCALE2X_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // model state: frame shadows and the pixel result in flight
    int m_sx = 0, m_sy = 0, m_xo = 0, m_yo = 0, m_fl = 0;
    int p_idx = 0, p_hit = 0, p_valid = 0;

    typedef struct {
        bit ft;
        int c, r;
        bit act;
        int sx, sy, xo, yo;
        bit fl;
        int exp_addr;
        int exp_hit;
        int exp_idx;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input int c, input int r, input int a,
                                  output bit ib, output int ad);
        int du, dv, u, v, x, y;
        du = (((c - m_sx) % 1024) + 1024) % 1024;
        dv = (((r - m_sy) % 1024) + 1024) % 1024;
        ib = (a != 0) && du < 32 * SCALE && dv < 32 * SCALE;
        u  = du / SCALE;
        v  = dv / SCALE;
        if (m_fl != 0) u = 31 - u;
        x  = (m_xo + u) % 256;
        y  = (m_yo + v) % 128;
        ad = ib ? y * 256 + x : 0;
    endfunction

    task automatic step();
        bit ib;
        int ad;
        model(int'(col), int'(row), int'(active_in), ib, ad);
        @(posedge clk);
        #1;
        if (rst) begin
            chk("rst_rom_addr", int'(rom_addr), 0);
            chk("rst_pixel_idx", int'(pixel_idx), 0);
            chk("rst_pixel_hit", int'(pixel_hit), 0);
            chk("rst_pixel_valid", int'(pixel_valid), 0);
            m_sx = 0; m_sy = 0; m_xo = 0; m_yo = 0; m_fl = 0;
            p_idx = 0; p_hit = 0; p_valid = 0;
        end else begin
            chk("rom_addr", int'(rom_addr), ad);
            chk("pixel_idx", int'(pixel_idx), p_idx);
            chk("pixel_hit", int'(pixel_hit), p_hit);
            chk("pixel_valid", int'(pixel_valid), p_valid);
            p_idx   = ib ? int'(rom[ad]) : 0;
            p_hit   = (ib && rom[ad] != 6'd0) ? 1 : 0;
            p_valid = int'(active_in);
            if (frame_tick) begin
                m_sx = int'(sprite_x); m_sy = int'(sprite_y);
                m_xo = int'(x_offset); m_yo = int'(y_offset);
                m_fl = int'(flip_h);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        frame_tick = v.ft;
        col        = 10'(v.c);
        row        = 10'(v.r);
        active_in  = v.act;
        sprite_x   = 10'(v.sx);
        sprite_y   = 10'(v.sy);
        x_offset   = 8'(v.xo);
        y_offset   = 7'(v.yo);
        flip_h     = v.fl;
    endtask

    function automatic vec_t mk(bit ft, int c, int r, bit act, int sx, int sy,
                                int xo, int yo, bit fl, int ea, int eh, int ei);
        vec_t v;
        v = '{ft, c, r, act, sx, sy, xo, yo, fl, ea, eh, ei};
        return v;
    endfunction

    initial begin
        for (int a = 0; a < 32768; a++) rom[a] = 6'((a * 37 + 11) & 63);
        rom[8799] = 6'd5;
        rom[8778] = 6'd0;

        //         ft  col  row act  sx  sy  xo  yo fl  addr hit idx
        tbl.push_back(mk(1,   0,   0, 0, 100, 50, 64, 32, 0,    0, -1, -1));
        tbl.push_back(mk(0, 105,  52, 1, 100, 50, 64, 32, 0, 8773, -1, -1));
        tbl.push_back(mk(0, 131,  52, 1, 100, 50, 64, 32, 0, 8799,  1,  5));
        tbl.push_back(mk(0, 132,  52, 1, 100, 50, 64, 32, 0,    0,  0,  0));
        tbl.push_back(mk(0, 110,  52, 1, 100, 50, 64, 32, 0, 8778,  0,  0));
        tbl.push_back(mk(1, 100,  50, 1, 100, 50, 64, 32, 1, 8256, -1, -1));
        tbl.push_back(mk(0, 100,  52, 1, 100, 50, 64, 32, 1, 8799,  1,  5));
        tbl.push_back(mk(0, 100,  52, 1, 100, 50, 96, 32, 1, 8799,  1,  5));
        tbl.push_back(mk(1, 100,  52, 1, 100, 50, 96, 32, 0, 8799,  1,  5));
        tbl.push_back(mk(0, 100,  52, 1, 100, 50, 96, 32, 0, 8800, -1, -1));
        tbl.push_back(mk(0, 100,  52, 0, 100, 50, 96, 32, 0,    0,  0,  0));
        tbl.push_back(mk(1,   0,   0, 0,1020,  0,  0,  0, 0,    0, -1, -1));
        tbl.push_back(mk(0,   2,   3, 1,1020,  0,  0,  0, 0,  774, -1, -1));
        tbl.push_back(mk(1,   2,   3, 1,  10,  0,  0,  0, 0,  774, -1, -1));
        tbl.push_back(mk(0,   5,   3, 1,  10,  0,  0,  0, 0,    0,  0,  0));
        tbl.push_back(mk(1,   5,   3, 1,   0,  0,240,120, 0,    0,  0,  0));
        tbl.push_back(mk(0,  20,  10, 1,   0,  0,240,120, 0,  516, -1, -1));
        tbl.push_back(mk(0,  20,   9, 1,   0,  0,240,120, 0,  260, -1, -1));
        tbl.push_back(mk(0,   0,   0, 0,   0,  0,  0,  0, 0,    0, -1, -1));

        // reset with an active pixel presented
        rst = 1'b1;
        active_in = 1'b1; col = 10'd5; row = 10'd5;
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            step();
            if (SCALE == 1) begin
                chk($sformatf("tbl%0d_rom_addr", i), int'(rom_addr), tbl[i].exp_addr);
                if (i > 0 && tbl[i-1].exp_hit >= 0) begin
                    chk($sformatf("tbl%0d_hit", i - 1), int'(pixel_hit), tbl[i-1].exp_hit);
                    chk($sformatf("tbl%0d_idx", i - 1), int'(pixel_idx), tbl[i-1].exp_idx);
                end
            end
        end

        // mid-line reset: flush, then outputs come back two cycles later
        apply(mk(1, 105, 52, 1, 100, 50, 64, 32, 0, 0, -1, -1));
        step();
        frame_tick = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("async_rst_rom_addr", int'(rom_addr), 0);
        chk("async_rst_valid", int'(pixel_valid), 0);
        step();
        step();
        rst = 1'b0;
        apply(mk(1, 3, 2, 1, 0, 0, 8, 4, 0, 0, -1, -1));
        step();
        frame_tick = 1'b0;
        step();
        chk("resume_rom_addr", int'(rom_addr), 6 * 256 + 11);
        step();
        chk("resume_valid", int'(pixel_valid), 1);

        // randomized pixels near the sprite box
        for (int n = 0; n < 600; n++) begin
            frame_tick = ($urandom_range(0, 15) == 0);
            if (frame_tick) begin
                sprite_x = 10'($urandom);
                sprite_y = 10'($urandom);
                x_offset = 8'($urandom);
                y_offset = 7'($urandom);
                flip_h   = 1'($urandom);
            end
            col = 10'(m_sx + $urandom_range(0, 32 * SCALE + 8) - 4);
            row = 10'(m_sy + $urandom_range(0, 32 * SCALE + 8) - 4);
            active_in = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
